// File: rtl/cmos_pixel_assembler.sv
// DVP byte-stream to RGB565 pixel assembler with post-reset frame skipping
// and per-frame geometry checking. Single clock domain on the sensor pixel clock.
module cmos_pixel_assembler #(
  parameter int VIDEO_WIDTH  = 1280,
  parameter int VIDEO_HEIGHT = 720,
  parameter int SKIP_FRAMES  = 10,
  parameter int BYTE_ORDER   = 0
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_data,
  output logic        vs_out,
  output logic        hs_out,
  output logic        de_out,
  output logic [15:0] data_out,
  output logic        init_done,
  output logic [7:0]  frame_cnt,
  output logic        size_err
);

  localparam logic [11:0] WIDTH  = 12'(VIDEO_WIDTH);
  localparam logic [10:0] HEIGHT = 11'(VIDEO_HEIGHT);
  localparam logic [7:0]  SKIP   = 8'(SKIP_FRAMES);

  logic        vsync_s1;
  logic        href_s1;
  logic [7:0]  data_s1;
  logic        href_d;
  logic        byte_phase;
  logic [7:0]  byte_hold;
  logic [11:0] pix_cnt;
  logic [10:0] line_cnt;
  logic [10:0] line_next;
  logic        err_acc;
  logic        err_next;
  logic        frame_err;
  logic [7:0]  skip_cnt;
  logic        href_eff;
  logic        href_rise;
  logic        href_fall;
  logic        frame_end;
  logic        frame_start;

  // vs_out doubles as the one-cycle-delayed vsync used for edge detection.
  assign href_eff    = href_s1 & ~vsync_s1;
  assign href_rise   = href_eff & ~href_d;
  assign href_fall   = ~href_eff & href_d;
  assign frame_end   = vsync_s1 & ~vs_out;
  assign frame_start = ~vsync_s1 & vs_out;
  assign init_done   = (skip_cnt == SKIP);
  assign hs_out      = href_d & init_done;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      vsync_s1 <= 1'b0;
      href_s1  <= 1'b0;
      data_s1  <= 8'd0;
      vs_out   <= 1'b0;
      href_d   <= 1'b0;
    end else begin
      vsync_s1 <= cmos_vsync;
      href_s1  <= cmos_href;
      data_s1  <= cmos_data;
      vs_out   <= vsync_s1;
      href_d   <= href_eff;
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      byte_phase <= 1'b0;
      byte_hold  <= 8'd0;
      de_out     <= 1'b0;
      data_out   <= 16'd0;
      pix_cnt    <= 12'd0;
    end else begin
      de_out <= 1'b0;
      if (href_eff) begin
        byte_phase <= ~byte_phase;
        if (!byte_phase) begin
          byte_hold <= data_s1;
        end else begin
          if (init_done) begin
            data_out <= (BYTE_ORDER == 0) ? {byte_hold, data_s1} : {data_s1, byte_hold};
            de_out   <= 1'b1;
          end
          if (pix_cnt != 12'hFFF) pix_cnt <= pix_cnt + 12'd1;
        end
        if (href_rise) pix_cnt <= 12'd0;
      end else begin
        byte_phase <= 1'b0;
      end
    end
  end

  // A line end can land on the frame-end cycle, so its effects are folded in combinationally.
  always_comb begin
    line_next = line_cnt;
    err_next  = err_acc;
    if (href_fall) begin
      if (line_cnt != 11'h7FF) line_next = line_cnt + 11'd1;
      if ((pix_cnt != WIDTH) || byte_phase) err_next = 1'b1;
    end
  end

  assign frame_err = err_next | (line_next != HEIGHT);

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      line_cnt  <= 11'd0;
      err_acc   <= 1'b0;
      skip_cnt  <= 8'd0;
      frame_cnt <= 8'd0;
      size_err  <= 1'b0;
    end else if (frame_start) begin
      line_cnt <= 11'd0;
      err_acc  <= 1'b0;
    end else if (frame_end) begin
      line_cnt <= line_next;
      err_acc  <= frame_err;
      if (skip_cnt < SKIP) skip_cnt <= skip_cnt + 8'd1;
      if (init_done) begin
        size_err  <= frame_err;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end else begin
      line_cnt <= line_next;
      err_acc  <= err_next;
    end
  end

endmodule

// File: tb/tb_cmos_pixel_assembler.sv
// Self-checking bench for cmos_pixel_assembler: W=8, H=4, two skipped frames,
// one instance per byte order driven from the same DVP stimulus.
module tb_cmos_pixel_assembler;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int SKIP = 2;

  logic        clk_in = 1'b0;
  logic        rst = 1'b0;
  logic        cmos_vsync = 1'b0;
  logic        cmos_href = 1'b0;
  logic [7:0]  cmos_data = 8'd0;

  logic        vs_out, hs_out, de_out, init_done, size_err;
  logic [15:0] data_out;
  logic [7:0]  frame_cnt;
  logic        vs1, hs1, de1, init1, size1;
  logic [15:0] data1;
  logic [7:0]  frame1;

  cmos_pixel_assembler #(.VIDEO_WIDTH(W), .VIDEO_HEIGHT(H), .SKIP_FRAMES(SKIP), .BYTE_ORDER(0)) dut0 (
    .clk_in(clk_in), .rst(rst), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href), .cmos_data(cmos_data),
    .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out), .data_out(data_out),
    .init_done(init_done), .frame_cnt(frame_cnt), .size_err(size_err));

  cmos_pixel_assembler #(.VIDEO_WIDTH(W), .VIDEO_HEIGHT(H), .SKIP_FRAMES(SKIP), .BYTE_ORDER(1)) dut1 (
    .clk_in(clk_in), .rst(rst), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href), .cmos_data(cmos_data),
    .vs_out(vs1), .hs_out(hs1), .de_out(de1), .data_out(data1),
    .init_done(init1), .frame_cnt(frame1), .size_err(size1));

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [15:0] exp0;
    logic [15:0] exp1;
  } vec_t;

  vec_t vecs [8];
  int checks = 0;
  int errors = 0;
  int de_cnt = 0;
  int de1_cnt = 0;
  int hs_cnt = 0;
  int de_outside = 0;
  logic [15:0] cap0 [$];
  logic [15:0] cap1 [$];

  always @(negedge clk_in) begin
    if (de_out) begin
      de_cnt <= de_cnt + 1;
      cap0.push_back(data_out);
    end
    if (de1) begin
      de1_cnt <= de1_cnt + 1;
      cap1.push_back(data1);
    end
    if (hs_out) hs_cnt <= hs_cnt + 1;
    if (de_out && !hs_out) de_outside <= de_outside + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_line(input int nbytes, input bit chk_lat);
    for (int i = 0; i < nbytes; i++) begin
      cmos_href = 1'b1;
      cmos_data = (i % 2 == 0) ? vecs[i / 2].b0 : vecs[i / 2].b1;
      tick();
      if (chk_lat && i == 1) check("lat_early_de", 32'(de_out), 32'd0);
      if (chk_lat && i == 2) begin
        check("lat_de", 32'(de_out), 32'd1);
        check("lat_data_order0", 32'(data_out), 32'hABCD);
        check("lat_data_order1", 32'(data1), 32'hCDAB);
      end
    end
    cmos_href = 1'b0;
    cmos_data = 8'd0;
    tick();
  endtask

  task automatic vsync_pulse(input bit with_href);
    int de_base;
    int hs_base;
    cmos_vsync = 1'b1;
    cmos_href  = 1'b0;
    tick();
    check("vs_lat_early", 32'(vs_out), 32'd0);
    tick();
    check("vs_lat", 32'(vs_out), 32'd1);
    if (with_href) begin
      de_base = de_cnt;
      hs_base = hs_cnt;
      for (int i = 0; i < 8; i++) begin
        cmos_href = (i != 3);
        cmos_data = 8'h55;
        tick();
      end
      cmos_href = 1'b0;
      repeat (3) tick();
      check("vs_href_de", 32'(de_cnt - de_base), 32'd0);
      check("vs_href_hs", 32'(hs_cnt - hs_base), 32'd0);
    end else begin
      repeat (4) tick();
    end
    cmos_vsync = 1'b0;
    repeat (4) tick();
  endtask

  task automatic send_frame(input int nlines, input int line1_bytes, input bit chk_lat, input bit href_in_vs);
    for (int l = 0; l < nlines; l++)
      send_line((l == 1) ? line1_bytes : 2 * W, chk_lat && (l == 0));
    repeat (2) tick();
    vsync_pulse(href_in_vs);
  endtask

  initial begin
    int de_base;
    int hs_base;
    int cap_base;

    vecs[0] = '{8'hAB, 8'hCD, 16'hABCD, 16'hCDAB};
    vecs[1] = '{8'h12, 8'h34, 16'h1234, 16'h3412};
    vecs[2] = '{8'h00, 8'hFF, 16'h00FF, 16'hFF00};
    vecs[3] = '{8'hFF, 8'h00, 16'hFF00, 16'h00FF};
    vecs[4] = '{8'hF8, 8'h1F, 16'hF81F, 16'h1FF8};
    vecs[5] = '{8'h07, 8'hE0, 16'h07E0, 16'hE007};
    vecs[6] = '{8'h5A, 8'hA5, 16'h5AA5, 16'hA55A};
    vecs[7] = '{8'h80, 8'h01, 16'h8001, 16'h0180};

    repeat (3) tick();
    check("rst_vs_out", 32'(vs_out), 32'd0);
    check("rst_hs_out", 32'(hs_out), 32'd0);
    check("rst_de_out", 32'(de_out), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_size_err", 32'(size_err), 32'd0);
    rst = 1'b1;
    tick();

    // Two skipped frames
    send_frame(H, 2 * W, 1'b0, 1'b0);
    check("skip1_init_done", 32'(init_done), 32'd0);
    check("skip1_de", 32'(de_cnt), 32'd0);
    send_frame(H, 2 * W, 1'b0, 1'b0);
    check("skip2_init_done", 32'(init_done), 32'd1);
    check("skip2_de", 32'(de_cnt), 32'd0);
    check("skip2_hs", 32'(hs_cnt), 32'd0);
    check("skip2_frame_cnt", 32'(frame_cnt), 32'd0);

    // First forwarded frame: latency, pixel contents from the vector table
    de_base  = de_cnt;
    hs_base  = hs_cnt;
    cap_base = cap0.size();
    send_frame(H, 2 * W, 1'b1, 1'b0);
    check("f3_de", 32'(de_cnt - de_base), 32'(W * H));
    check("f3_de_order1", 32'(de1_cnt), 32'(W * H));
    check("f3_hs", 32'(hs_cnt - hs_base), 32'(2 * W * H));
    check("f3_frame_cnt", 32'(frame_cnt), 32'd1);
    check("f3_size_err", 32'(size_err), 32'd0);
    for (int i = 0; i < W; i++) begin
      check($sformatf("pix_order0_%0d", i),
            (cap_base + i < cap0.size()) ? 32'(cap0[cap_base + i]) : 32'hDEADBEEF, 32'(vecs[i].exp0));
      check($sformatf("pix_order1_%0d", i),
            (cap_base + i < cap1.size()) ? 32'(cap1[cap_base + i]) : 32'hDEADBEEF, 32'(vecs[i].exp1));
    end

    de_base = de_cnt;
    send_frame(H, 2 * W, 1'b0, 1'b0);
    check("f4_de", 32'(de_cnt - de_base), 32'(W * H));
    check("f4_frame_cnt", 32'(frame_cnt), 32'd2);
    check("f4_size_err", 32'(size_err), 32'd0);

    // Line 2 with 7 pairs and a dangling byte
    de_base = de_cnt;
    send_frame(H, 2 * W - 1, 1'b0, 1'b0);
    check("dangle_de", 32'(de_cnt - de_base), 32'(W * H - 1));
    check("dangle_size_err", 32'(size_err), 32'd1);
    check("dangle_frame_cnt", 32'(frame_cnt), 32'd3);

    send_frame(H, 2 * W, 1'b0, 1'b0);
    check("recover_size_err", 32'(size_err), 32'd0);
    check("recover_frame_cnt", 32'(frame_cnt), 32'd4);

    // Short frame: three lines
    de_base = de_cnt;
    send_frame(H - 1, 2 * W, 1'b0, 1'b0);
    check("short_de", 32'(de_cnt - de_base), 32'(W * (H - 1)));
    check("short_size_err", 32'(size_err), 32'd1);
    check("short_frame_cnt", 32'(frame_cnt), 32'd5);

    // href activity while vsync is high must be ignored
    send_frame(H, 2 * W, 1'b0, 1'b1);
    check("f8_size_err", 32'(size_err), 32'd0);
    check("f8_frame_cnt", 32'(frame_cnt), 32'd6);
    de_base = de_cnt;
    send_frame(H, 2 * W, 1'b0, 1'b0);
    check("f9_de", 32'(de_cnt - de_base), 32'(W * H));
    check("f9_size_err", 32'(size_err), 32'd0);
    check("f9_frame_cnt", 32'(frame_cnt), 32'd7);

    // Reset in the middle of a forwarded line
    for (int i = 0; i < 6; i++) begin
      cmos_href = 1'b1;
      cmos_data = (i % 2 == 0) ? vecs[i / 2].b0 : vecs[i / 2].b1;
      tick();
    end
    rst = 1'b0;
    cmos_href = 1'b0;
    #1;
    check("midrst_outs_async",
          32'({vs_out, hs_out, de_out, data_out, init_done, frame_cnt, size_err}), 32'd0);
    repeat (3) tick();
    check("midrst_outs_held",
          32'({vs_out, hs_out, de_out, data_out, init_done, frame_cnt, size_err}), 32'd0);
    rst = 1'b1;
    repeat (2) tick();
    vsync_pulse(1'b0);
    check("midrst_skip1_init", 32'(init_done), 32'd0);
    de_base = de_cnt;
    send_frame(H, 2 * W, 1'b0, 1'b0);
    check("midrst_skip2_init", 32'(init_done), 32'd1);
    check("midrst_skip2_de", 32'(de_cnt - de_base), 32'd0);
    check("midrst_skip2_frame_cnt", 32'(frame_cnt), 32'd0);
    de_base = de_cnt;
    send_frame(H, 2 * W, 1'b0, 1'b0);
    check("midrst_fwd_de", 32'(de_cnt - de_base), 32'(W * H));
    check("midrst_fwd_frame_cnt", 32'(frame_cnt), 32'd1);
    check("midrst_fwd_size_err", 32'(size_err), 32'd0);

    tick();
    check("de_outside_hs", 32'(de_outside), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
